// File: rtl/tracker_scheduler.sv
// Two-axis solar tracker sequencer: compares paired light sensors and steps the
// horizontal then vertical servo one at a time, each step followed by a settle period.
module tracker_scheduler #(
  parameter int DATA_W        = 10,
  parameter int DEADBAND      = 16,
  parameter int MOVE_CYCLES   = 100000,
  parameter int SETTLE_CYCLES = 2000000,
  parameter int POS_MAX       = 180,
  parameter int POS_INIT      = 90
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ENABLE,
  input  logic              SAMPLE_VALID,
  input  logic [DATA_W-1:0] LDR_L,
  input  logic [DATA_W-1:0] LDR_R,
  input  logic [DATA_W-1:0] LDR_T,
  input  logic [DATA_W-1:0] LDR_B,
  output logic              H_BTN_0,
  output logic              H_BTN_1,
  output logic              V_BTN_0,
  output logic              V_BTN_1,
  output logic [7:0]        H_POS,
  output logic [7:0]        V_POS,
  output logic              BUSY,
  output logic              LOCKED
);

  localparam int CNT_MAX = (MOVE_CYCLES > SETTLE_CYCLES) ? MOVE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] MOVE_LAST   = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EVAL_H, S_MOVE_H, S_SETTLE_H, S_EVAL_V, S_MOVE_V, S_SETTLE_V
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_inc_q, dir_inc_d;
  logic               h_moved_q, h_moved_d;
  logic [DATA_W-1:0]  l_q, r_q, t_q, b_q;
  logic               latch, h_step, v_step, lock_upd, lock_val;

  logic signed [DATA_W:0] diff_h, diff_v;
  logic h_up, h_dn, v_up, v_dn;

  // Differences are one bit wider than the readings so they never overflow.
  assign diff_h = $signed({1'b0, l_q}) - $signed({1'b0, r_q});
  assign diff_v = $signed({1'b0, t_q}) - $signed({1'b0, b_q});

  assign h_up = (int'(diff_h) >  DEADBAND) && (int'(H_POS) < POS_MAX);
  assign h_dn = (int'(diff_h) < -DEADBAND) && (H_POS != 8'd0);
  assign v_up = (int'(diff_v) >  DEADBAND) && (int'(V_POS) < POS_MAX);
  assign v_dn = (int'(diff_v) < -DEADBAND) && (V_POS != 8'd0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dir_inc_q <= 1'b0;
      h_moved_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_inc_q <= dir_inc_d;
      h_moved_q <= h_moved_d;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_inc_d = dir_inc_q;
    h_moved_d = h_moved_q;
    latch     = 1'b0;
    h_step    = 1'b0;
    v_step    = 1'b0;
    lock_upd  = 1'b0;
    lock_val  = LOCKED;

    if (state_q != S_IDLE && !ENABLE) begin
      // Abort: drop out without committing the step or touching LOCKED.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ENABLE && SAMPLE_VALID) begin
            latch     = 1'b1;
            h_moved_d = 1'b0;
            state_d   = S_EVAL_H;
          end
        end
        S_EVAL_H: begin
          if (h_up || h_dn) begin
            dir_inc_d = h_up;
            h_moved_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_MOVE_H;
          end else begin
            state_d = S_EVAL_V;
          end
        end
        S_MOVE_H: begin
          if (cnt_q == MOVE_LAST) begin
            h_step  = 1'b1;
            cnt_d   = '0;
            state_d = S_SETTLE_H;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SETTLE_H: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = S_EVAL_V;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_EVAL_V: begin
          if (v_up || v_dn) begin
            dir_inc_d = v_up;
            cnt_d     = '0;
            state_d   = S_MOVE_V;
          end else begin
            state_d  = S_IDLE;
            lock_upd = 1'b1;
            lock_val = !h_moved_q;
          end
        end
        S_MOVE_V: begin
          if (cnt_q == MOVE_LAST) begin
            v_step  = 1'b1;
            cnt_d   = '0;
            state_d = S_SETTLE_V;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SETTLE_V: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d    = '0;
            state_d  = S_IDLE;
            lock_upd = 1'b1;
            lock_val = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      H_BTN_0 <= 1'b0;
      H_BTN_1 <= 1'b0;
      V_BTN_0 <= 1'b0;
      V_BTN_1 <= 1'b0;
      BUSY    <= 1'b0;
      LOCKED  <= 1'b0;
      H_POS   <= 8'(POS_INIT);
      V_POS   <= 8'(POS_INIT);
      l_q     <= '0;
      r_q     <= '0;
      t_q     <= '0;
      b_q     <= '0;
    end else begin
      H_BTN_0 <= (state_d == S_MOVE_H) &&  dir_inc_d;
      H_BTN_1 <= (state_d == S_MOVE_H) && !dir_inc_d;
      V_BTN_0 <= (state_d == S_MOVE_V) &&  dir_inc_d;
      V_BTN_1 <= (state_d == S_MOVE_V) && !dir_inc_d;
      BUSY    <= (state_d != S_IDLE);
      if (lock_upd) LOCKED <= lock_val;
      // Limits were checked at evaluation, so a committed step cannot wrap.
      if (h_step) H_POS <= dir_inc_q ? H_POS + 8'd1 : H_POS - 8'd1;
      if (v_step) V_POS <= dir_inc_q ? V_POS + 8'd1 : V_POS - 8'd1;
      if (latch) begin
        l_q <= LDR_L;
        r_q <= LDR_R;
        t_q <= LDR_T;
        b_q <= LDR_B;
      end
    end
  end

endmodule

// File: tb/tb_tracker_scheduler.sv
// Bench for tracker_scheduler: a pass-timeline model checked every cycle, directed
// scenarios with literal expectations, and randomized sensor readings.
module tb_tracker_scheduler;

  localparam int DW = 10;
  localparam int MC = 4;
  localparam int SC = 3;
  localparam int DB = 16;
  localparam int PM = 180;
  localparam int PI = 90;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_lim_n = 1'b0;
  logic enable = 1'b0;
  logic sample_valid = 1'b0;
  logic [DW-1:0] ldr_l = '0, ldr_r = '0, ldr_t = '0, ldr_b = '0;

  logic h_btn_0, h_btn_1, v_btn_0, v_btn_1, busy, locked;
  logic [7:0] h_pos, v_pos;
  logic hi_h0, hi_h1, hi_v0, hi_v1, hi_busy, hi_locked;
  logic [7:0] hi_hpos, hi_vpos;
  logic lo_h0, lo_h1, lo_v0, lo_v1, lo_busy, lo_locked;
  logic [7:0] lo_hpos, lo_vpos;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tracker_scheduler #(.DATA_W(DW), .DEADBAND(DB), .MOVE_CYCLES(MC), .SETTLE_CYCLES(SC),
                      .POS_MAX(PM), .POS_INIT(PI)) dut (
    .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .SAMPLE_VALID(sample_valid),
    .LDR_L(ldr_l), .LDR_R(ldr_r), .LDR_T(ldr_t), .LDR_B(ldr_b),
    .H_BTN_0(h_btn_0), .H_BTN_1(h_btn_1), .V_BTN_0(v_btn_0), .V_BTN_1(v_btn_1),
    .H_POS(h_pos), .V_POS(v_pos), .BUSY(busy), .LOCKED(locked));

  tracker_scheduler #(.DATA_W(DW), .DEADBAND(DB), .MOVE_CYCLES(MC), .SETTLE_CYCLES(SC),
                      .POS_MAX(PM), .POS_INIT(180)) dut_hi (
    .CLK(clk), .RST_N(rst_lim_n), .ENABLE(enable), .SAMPLE_VALID(sample_valid),
    .LDR_L(ldr_l), .LDR_R(ldr_r), .LDR_T(ldr_t), .LDR_B(ldr_b),
    .H_BTN_0(hi_h0), .H_BTN_1(hi_h1), .V_BTN_0(hi_v0), .V_BTN_1(hi_v1),
    .H_POS(hi_hpos), .V_POS(hi_vpos), .BUSY(hi_busy), .LOCKED(hi_locked));

  tracker_scheduler #(.DATA_W(DW), .DEADBAND(DB), .MOVE_CYCLES(MC), .SETTLE_CYCLES(SC),
                      .POS_MAX(PM), .POS_INIT(0)) dut_lo (
    .CLK(clk), .RST_N(rst_lim_n), .ENABLE(enable), .SAMPLE_VALID(sample_valid),
    .LDR_L(ldr_l), .LDR_R(ldr_r), .LDR_T(ldr_t), .LDR_B(ldr_b),
    .H_BTN_0(lo_h0), .H_BTN_1(lo_h1), .V_BTN_0(lo_v0), .V_BTN_1(lo_v1),
    .H_POS(lo_hpos), .V_POS(lo_vpos), .BUSY(lo_busy), .LOCKED(lo_locked));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: on acceptance, the whole pass is laid out as a queue of per-cycle slots.
  typedef struct {
    logic h0, h1, v0, v1;
    int   dh, dv;
    logic lock_upd, lock_val;
  } slot_t;

  slot_t plan[$];
  int    m_hpos, m_vpos;
  logic  m_locked;

  task automatic push_slot(input logic h0, h1, v0, v1, input int dh, dv, input logic lu, lv);
    slot_t s;
    s.h0 = h0; s.h1 = h1; s.v0 = v0; s.v1 = v1;
    s.dh = dh; s.dv = dv; s.lock_upd = lu; s.lock_val = lv;
    plan.push_back(s);
  endtask

  function automatic int axis_dir(input int a, input int b, input int pos);
    int d;
    d = a - b;
    if (d > DB && pos < PM) return 1;
    if (d < -DB && pos > 0) return -1;
    return 0;
  endfunction

  task automatic build_plan();
    int hd, vd;
    hd = axis_dir(int'(ldr_l), int'(ldr_r), m_hpos);
    vd = axis_dir(int'(ldr_t), int'(ldr_b), m_vpos);
    push_slot(0, 0, 0, 0, 0, 0, 0, 0);
    if (hd != 0) begin
      for (int i = 0; i < MC; i++) push_slot(hd > 0, hd < 0, 0, 0, (i == MC-1) ? hd : 0, 0, 0, 0);
      for (int i = 0; i < SC; i++) push_slot(0, 0, 0, 0, 0, 0, 0, 0);
    end
    push_slot(0, 0, 0, 0, 0, 0, vd == 0, hd == 0);
    if (vd != 0) begin
      for (int i = 0; i < MC; i++) push_slot(0, 0, vd > 0, vd < 0, 0, (i == MC-1) ? vd : 0, 0, 0);
      for (int i = 0; i < SC; i++) push_slot(0, 0, 0, 0, 0, 0, i == SC-1, 0);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plan.delete();
      m_hpos = PI;
      m_vpos = PI;
      m_locked = 1'b0;
    end else if (plan.size() != 0) begin
      if (!enable) begin
        plan.delete();
      end else begin
        slot_t s;
        s = plan.pop_front();
        m_hpos += s.dh;
        m_vpos += s.dv;
        if (s.lock_upd) m_locked = s.lock_val;
      end
    end else if (enable && sample_valid) begin
      build_plan();
    end
  end

  logic [21:0] exp_v, act_v;
  logic e_h0, e_h1, e_v0, e_v1;

  always @(negedge clk) begin
    e_h0 = 1'b0; e_h1 = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0;
    if (plan.size() != 0) begin
      e_h0 = plan[0].h0; e_h1 = plan[0].h1; e_v0 = plan[0].v0; e_v1 = plan[0].v1;
    end
    exp_v = {plan.size() != 0, m_locked, e_h0, e_h1, e_v0, e_v1, 8'(m_hpos), 8'(m_vpos)};
    act_v = {busy, locked, h_btn_0, h_btn_1, v_btn_0, v_btn_1, h_pos, v_pos};
    check("cycle_outputs", 32'(act_v), 32'(exp_v));
    check("pair_exclusive", 32'((h_btn_0 & h_btn_1) | (v_btn_0 & v_btn_1)), 0);
    check("axis_exclusive", 32'((h_btn_0 | h_btn_1) & (v_btn_0 | v_btn_1)), 0);
  end

  int p_busy, p_first, p_h0, p_h1, p_v0, p_v1, p_hi_h, p_lo_h;
  int pos_before;

  // Runs one accepted pass and gathers per-pass statistics until BUSY falls.
  task automatic run_pass(input logic [DW-1:0] l, r, t, b);
    int c;
    p_busy = 0; p_first = -1; p_h0 = 0; p_h1 = 0; p_v0 = 0; p_v1 = 0; p_hi_h = 0; p_lo_h = 0;
    @(negedge clk);
    enable = 1'b1; sample_valid = 1'b1;
    ldr_l = l; ldr_r = r; ldr_t = t; ldr_b = b;
    @(negedge clk);
    sample_valid = 1'b0;
    c = 1;
    while (c < 200 && busy) begin
      p_busy++;
      if (p_first < 0 && (h_btn_0 | h_btn_1 | v_btn_0 | v_btn_1)) p_first = c;
      p_h0 += int'(h_btn_0); p_h1 += int'(h_btn_1);
      p_v0 += int'(v_btn_0); p_v1 += int'(v_btn_1);
      p_hi_h += int'(hi_h0) + int'(hi_h1);
      p_lo_h += int'(lo_h0) + int'(lo_h1);
      @(negedge clk);
      c++;
    end
    check("pass_completes", 32'(c < 200), 1);
  endtask

  initial begin
    // Reset state, sampled while reset is held.
    @(negedge clk);
    @(negedge clk);
    check("reset_btns", {28'd0, h_btn_0, h_btn_1, v_btn_0, v_btn_1}, 0);
    check("reset_busy_locked", {30'd0, busy, locked}, 0);
    check("reset_h_pos", 32'(h_pos), 90);
    check("reset_v_pos", 32'(v_pos), 90);
    check("reset_hi_pos", 32'(hi_hpos), 180);
    check("reset_lo_pos", 32'(lo_hpos), 0);
    rst_n = 1'b1;
    rst_lim_n = 1'b1;
    @(negedge clk);

    // Horizontal increment.
    run_pass(600, 500, 512, 512);
    check("hinc_busy_cycles", p_busy, 9);
    check("hinc_first_enable", p_first, 2);
    check("hinc_h0_cycles", p_h0, 4);
    check("hinc_other_enables", p_h1 + p_v0 + p_v1, 0);
    check("hinc_h_pos", 32'(h_pos), 91);
    check("hinc_v_pos", 32'(v_pos), 90);
    check("hinc_locked", 32'(locked), 0);

    // Deadband boundary: +16 does not move, -17 does.
    pos_before = int'(h_pos);
    run_pass(516, 500, 500, 517);
    check("db_h_enables", p_h0 + p_h1, 0);
    check("db_v1_cycles", p_v1, 4);
    check("db_v0_cycles", p_v0, 0);
    check("db_first_enable", p_first, 3);
    check("db_busy_cycles", p_busy, 9);
    check("db_v_pos", 32'(v_pos), 89);
    check("db_h_pos", 32'(h_pos), 32'(pos_before));

    // Travel limits on the instances reset at 180 and 0.
    rst_lim_n = 1'b0;
    @(negedge clk);
    rst_lim_n = 1'b1;
    run_pass(700, 100, 512, 512);
    check("limit_hi_enables", p_hi_h, 0);
    check("limit_hi_pos", 32'(hi_hpos), 180);
    check("limit_main_h_pos", 32'(h_pos), 92);
    rst_lim_n = 1'b0;
    @(negedge clk);
    rst_lim_n = 1'b1;
    run_pass(100, 700, 512, 512);
    check("limit_lo_enables", p_lo_h, 0);
    check("limit_lo_pos", 32'(lo_hpos), 0);
    check("limit_main_h_pos_dec", 32'(h_pos), 91);

    // Balanced readings lock the tracker.
    run_pass(512, 512, 512, 512);
    check("bal_busy_cycles", p_busy, 2);
    check("bal_enables", p_h0 + p_h1 + p_v0 + p_v1, 0);
    check("bal_locked", 32'(locked), 1);

    // Abort in the second move cycle, with a strobe in the abort cycle.
    @(negedge clk);
    enable = 1'b1; sample_valid = 1'b1;
    ldr_l = 600; ldr_r = 500; ldr_t = 512; ldr_b = 512;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    check("abort_move1_enable", 32'(h_btn_0), 1);
    @(negedge clk);
    check("abort_move2_enable", 32'(h_btn_0), 1);
    enable = 1'b0; sample_valid = 1'b1;
    @(negedge clk);
    check("abort_enable_dropped", 32'(h_btn_0), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_h_pos", 32'(h_pos), 91);
    check("abort_locked_kept", 32'(locked), 1);
    enable = 1'b1; sample_valid = 1'b0;
    @(negedge clk);
    check("abort_strobe_ignored", 32'(busy), 0);

    // Asynchronous reset mid-move.
    enable = 1'b1; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    check("areset_pre_enable", 32'(h_btn_0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_enable", 32'(h_btn_0), 0);
    check("areset_busy", 32'(busy), 0);
    check("areset_locked", 32'(locked), 0);
    check("areset_h_pos", 32'(h_pos), 90);
    @(negedge clk);
    rst_n = 1'b1;

    // Random readings near balance with occasional enable drops.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 19) != 0);
      sample_valid = ($urandom_range(0, 3) == 0);
      ldr_l = DW'(480 + $urandom_range(0, 64));
      ldr_r = DW'(480 + $urandom_range(0, 64));
      ldr_t = DW'(480 + $urandom_range(0, 64));
      ldr_b = DW'(480 + $urandom_range(0, 64));
    end

    // Strong skew drives H to its upper limit and V to its lower limit.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      enable = 1'b1;
      sample_valid = 1'b1;
      ldr_l = DW'(700 + $urandom_range(0, 300));
      ldr_r = DW'($urandom_range(0, 100));
      ldr_t = DW'($urandom_range(0, 100));
      ldr_b = DW'(700 + $urandom_range(0, 300));
    end
    @(negedge clk);
    sample_valid = 1'b0;
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    check("sat_idle", 32'(busy), 0);
    check("sat_h_pos", 32'(h_pos), 180);
    check("sat_v_pos", 32'(v_pos), 0);
    check("sat_locked", 32'(locked), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
